// File: rtl/line_buff_scheduler.sv
// Double-buffered tile-row scheduler for a scan-out pipeline.
// Two line buffers each hold one tile row (TILE_WIDTH lines). While one
// buffer is displayed, the other is filled with the next tile row.
//
// Ports
//   clk_i             rising-edge clock
//   rstn_i            asynchronous active-low reset
//   frame_start_i     pulse in vertical blanking, before the first line
//   line_start_i      pulse at the start of each visible line
//   pxl_en_i          strobe per displayed pixel
//   buff_fill_done_i  per-buffer fill-complete pulse
//   buff_fill_req_o   per-buffer fill request (level, one-hot or zero)
//   buff_sel_o        one-hot buffer on display, 00 = none
//   disp_pxl_id_o     tile index of the current display pixel
//   underrun_o        sticky: displayed a tile row whose fill was pending
//   frame_err_o       sticky: frame sequencing violation
//
// state      | meaning
// IDLE       | after reset, waiting for the first frame_start_i
// PRIME      | filling tile row 0 into buffer 0 (possibly after a pending fill)
// READY      | row 0 buffered, waiting for the first visible line
// DISPLAY    | lines in progress (frozen once all visible lines are seen)
module line_buff_scheduler #(
   parameter int WIDTH_PX       = 640,
   parameter int HEIGHT_PX      = 480,
   parameter int TILE_WIDTH     = 4,
   parameter int TILE_CTR_WIDTH = $clog2(WIDTH_PX / TILE_WIDTH)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      frame_start_i,
   input  logic                      line_start_i,
   input  logic                      pxl_en_i,
   input  logic [1:0]                buff_fill_done_i,
   output logic [1:0]                buff_fill_req_o,
   output logic [1:0]                buff_sel_o,
   output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
   output logic                      underrun_o,
   output logic                      frame_err_o
);

   localparam int TILES_PER_LINE = WIDTH_PX / TILE_WIDTH;
   localparam int TILE_ROWS      = HEIGHT_PX / TILE_WIDTH;
   localparam int SUB_W          = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
   localparam int ROW_W          = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
   localparam int FILL_W         = $clog2(TILE_ROWS + 1);

   localparam logic [SUB_W-1:0]          SUB_MAX = SUB_W'(TILE_WIDTH - 1);
   localparam logic [ROW_W-1:0]          ROW_MAX = ROW_W'(TILE_ROWS - 1);
   localparam logic [TILE_CTR_WIDTH-1:0] PXL_MAX = TILE_CTR_WIDTH'(TILES_PER_LINE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_READY, ST_DISPLAY} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                req_q, req_d, sel_q, sel_d, defer_buf_q, defer_buf_d;
   logic [TILE_CTR_WIDTH-1:0] pxl_q, pxl_d;
   logic [SUB_W-1:0]          sub_q, sub_d, line_q, line_d;
   logic [ROW_W-1:0]          row_q, row_d;
   logic [FILL_W-1:0]         fill_q, fill_d, fill_inc;
   logic                      frozen_q, frozen_d;
   logic                      wait_q, wait_d;
   logic                      defer_q, defer_d;
   logic                      und_q, und_d, err_q, err_d;

   logic [1:0] done_hit, req_open, next_buf;
   logic       done_bad, ls, active, ls_take;

   assign done_hit = buff_fill_done_i & req_q;
   assign done_bad = |(buff_fill_done_i & ~req_q);
   // request still outstanding after this cycle's done pulses
   assign req_open = req_q & ~done_hit;
   assign ls       = line_start_i & ~frame_start_i;
   assign active   = (state_q == ST_READY) || (state_q == ST_DISPLAY);
   assign ls_take  = ls & active & ~frozen_q;
   assign next_buf = row_q[0] ? 2'b01 : 2'b10;
   assign fill_inc = fill_q + ((|done_hit) ? FILL_W'(1) : FILL_W'(0));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (frame_start_i) state_d = ST_PRIME;
         ST_PRIME:   if (done_hit[0] && !wait_q) state_d = ST_READY;
         ST_READY: begin
            if (frame_start_i)     state_d = ST_PRIME;
            else if (line_start_i) state_d = ST_DISPLAY;
         end
         ST_DISPLAY: if (frame_start_i) state_d = ST_PRIME;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_d       = req_open;
      sel_d       = sel_q;
      pxl_d       = pxl_q;
      sub_d       = sub_q;
      line_d      = line_q;
      row_d       = row_q;
      fill_d      = fill_q;
      frozen_d    = frozen_q;
      wait_d      = wait_q;
      defer_d     = defer_q;
      defer_buf_d = defer_buf_q;
      und_d       = und_q;
      err_d       = err_q | done_bad;

      // a done for a fill left over from the previous frame is not counted
      if (!(state_q == ST_PRIME && wait_q)) fill_d = fill_inc;

      case (state_q)
         ST_IDLE: if (frame_start_i) begin
            req_d  = 2'b01;
            fill_d = '0;
         end
         ST_PRIME: begin
            if (frame_start_i) err_d = 1'b1;
            if (ls)            und_d = 1'b1;
            if (wait_q) begin
               if (|done_hit) wait_d = 1'b0;
            end else if (req_q == 2'b00) begin
               req_d = 2'b01;
            end
         end
         ST_READY, ST_DISPLAY: begin
            if (frame_start_i) begin
               sel_d    = 2'b00;
               line_d   = '0;
               row_d    = '0;
               frozen_d = 1'b0;
               defer_d  = 1'b0;
               fill_d   = '0;
               if (fill_inc != FILL_W'(TILE_ROWS)) err_d = 1'b1;
               // finish the old fill before row 0 may reuse a buffer
               if (req_open != 2'b00) wait_d = 1'b1;
               else                   req_d  = 2'b01;
            end else begin
               if (ls && frozen_q) err_d = 1'b1;
               // request postponed by an underrun, issued once the bus is idle
               if (defer_q && req_q == 2'b00) begin
                  req_d   = defer_buf_q;
                  defer_d = 1'b0;
               end
               if (ls_take && line_q == '0) begin
                  sel_d = row_q[0] ? 2'b10 : 2'b01;
                  if (req_open != 2'b00 || defer_q) und_d = 1'b1;
                  if (row_q != ROW_MAX) begin
                     if (req_open == 2'b00 && !defer_q) begin
                        req_d = next_buf;
                     end else begin
                        defer_d     = 1'b1;
                        defer_buf_d = next_buf;
                     end
                  end
               end
               if (ls_take) begin
                  if (line_q == SUB_MAX) begin
                     if (row_q == ROW_MAX) begin
                        frozen_d = 1'b1;
                     end else begin
                        line_d = '0;
                        row_d  = row_q + ROW_W'(1);
                     end
                  end else begin
                     line_d = line_q + SUB_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase

      if (ls_take) begin
         pxl_d = '0;
         sub_d = '0;
      end else if (pxl_en_i) begin
         if (sub_q == SUB_MAX) begin
            sub_d = '0;
            if (pxl_q != PXL_MAX) pxl_d = pxl_q + TILE_CTR_WIDTH'(1);
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         req_q       <= 2'b00;
         sel_q       <= 2'b00;
         pxl_q       <= '0;
         sub_q       <= '0;
         line_q      <= '0;
         row_q       <= '0;
         fill_q      <= '0;
         frozen_q    <= 1'b0;
         wait_q      <= 1'b0;
         defer_q     <= 1'b0;
         defer_buf_q <= 2'b00;
         und_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         req_q       <= req_d;
         sel_q       <= sel_d;
         pxl_q       <= pxl_d;
         sub_q       <= sub_d;
         line_q      <= line_d;
         row_q       <= row_d;
         fill_q      <= fill_d;
         frozen_q    <= frozen_d;
         wait_q      <= wait_d;
         defer_q     <= defer_d;
         defer_buf_q <= defer_buf_d;
         und_q       <= und_d;
         err_q       <= err_d;
      end
   end

   assign buff_fill_req_o = req_q;
   assign buff_sel_o      = sel_q;
   assign disp_pxl_id_o   = pxl_q;
   assign underrun_o      = und_q;
   assign frame_err_o     = err_q;

endmodule

// File: tb/tb_line_buff_scheduler.sv
module tb_line_buff_scheduler;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       fs, ls, pe;
   logic [1:0] dn;
   logic [1:0] req, sel;
   logic [7:0] pxl;
   logic       und, err;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   line_buff_scheduler dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .frame_start_i    (fs),
      .line_start_i     (ls),
      .pxl_en_i         (pe),
      .buff_fill_done_i (dn),
      .buff_fill_req_o  (req),
      .buff_sel_o       (sel),
      .disp_pxl_id_o    (pxl),
      .underrun_o       (und),
      .frame_err_o      (err)
   );

   typedef struct {
      logic       f, l, p;
      logic [1:0] d;
      logic [1:0] rq, sl;
      int         px;
      logic       u, e;
   } vec_t;

   vec_t tbl[$];

   // random-run reference state
   int         line_idx, px_cnt, fills, cd;
   logic       armed;
   logic [1:0] prev_req;

   function automatic vec_t mk(input logic f, l, p, input logic [1:0] d,
                               input logic [1:0] rq, sl, input int px,
                               input logic u, e);
      vec_t v;
      v.f = f; v.l = l; v.p = p; v.d = d;
      v.rq = rq; v.sl = sl; v.px = px; v.u = u; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic f, input logic l, input logic p, input logic [1:0] d);
      fs = f; ls = l; pe = p; dn = d;
      @(posedge clk_i);
      #1;
      fs = 1'b0; ls = 1'b0; pe = 1'b0; dn = 2'b00;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      fs = 1'b0; ls = 1'b0; pe = 1'b0; dn = 2'b00;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_req", 32'(req), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_pxl", 32'(pxl), 0);
      chk("rst_und", 32'(und), 0);
      chk("rst_err", 32'(err), 0);
      rstn_i = 1'b1;
      cyc(0, 0, 0, 2'b00);
   endtask

   // random cycle: the bench plays the line buffers with a random fill latency
   task automatic rcyc(input logic f, input logic l);
      logic       p;
      logic [1:0] d;
      int         exp_px, exp_sel;
      p = ($urandom_range(0, 2) != 0);
      d = 2'b00;
      if (armed) begin
         if (cd == 0) begin
            d     = req;
            armed = 1'b0;
         end else begin
            cd--;
         end
      end
      cyc(f, l, p, d);
      if (!f && l && line_idx < 479) begin
         line_idx++;
         px_cnt = 0;
      end else begin
         if (f) line_idx = -1;
         if (p) px_cnt++;
      end
      exp_px  = (px_cnt / 4 > 159) ? 159 : px_cnt / 4;
      exp_sel = (line_idx < 0) ? 0 : ((((line_idx / 4) % 2) == 1) ? 2 : 1);
      chk("rnd_pxl", 32'(pxl), 32'(exp_px));
      chk("rnd_sel", 32'(sel), 32'(exp_sel));
      chk("rnd_req_onehot", 32'((req & (req - 2'b01)) == 2'b00), 1);
      chk("rnd_req_sel_overlap", 32'(req & sel), 0);
      if (req != 2'b00 && prev_req == 2'b00) begin
         chk("rnd_fill_buf", 32'(req), ((fills % 2) == 1) ? 2 : 1);
         fills++;
         armed = 1'b1;
         cd    = $urandom_range(0, 15);
      end
      prev_req = req;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      //           f l p d     rq sl px u e
      tbl.push_back(mk(0,0,0,2'd0, 2'd0,2'd0,0,0,0));
      tbl.push_back(mk(1,0,0,2'd0, 2'd1,2'd0,0,0,0));
      tbl.push_back(mk(0,0,0,2'd0, 2'd1,2'd0,0,0,0));
      tbl.push_back(mk(0,0,0,2'd1, 2'd0,2'd0,0,0,0));
      tbl.push_back(mk(0,0,0,2'd0, 2'd0,2'd0,0,0,0));
      tbl.push_back(mk(0,1,0,2'd0, 2'd2,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd2,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd2,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd2, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd0,2'd1,1,0,0));
      tbl.push_back(mk(0,1,1,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,0,1,2'd0, 2'd0,2'd1,1,0,0));
      tbl.push_back(mk(0,1,0,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,1,0,2'd0, 2'd0,2'd1,0,0,0));
      tbl.push_back(mk(0,1,0,2'd0, 2'd1,2'd2,0,0,0));
      tbl.push_back(mk(0,0,0,2'd1, 2'd0,2'd2,0,0,0));
      tbl.push_back(mk(0,0,0,2'd2, 2'd0,2'd2,0,0,1));
      tbl.push_back(mk(0,1,0,2'd0, 2'd0,2'd2,0,0,1));
      tbl.push_back(mk(0,1,0,2'd0, 2'd0,2'd2,0,0,1));
      tbl.push_back(mk(0,1,0,2'd0, 2'd0,2'd2,0,0,1));
      tbl.push_back(mk(0,1,0,2'd0, 2'd2,2'd1,0,0,1));
      tbl.push_back(mk(0,0,0,2'd1, 2'd2,2'd1,0,0,1));
      tbl.push_back(mk(1,1,0,2'd0, 2'd2,2'd0,0,0,1));
      tbl.push_back(mk(0,0,0,2'd2, 2'd0,2'd0,0,0,1));
      tbl.push_back(mk(0,0,0,2'd0, 2'd1,2'd0,0,0,1));
      tbl.push_back(mk(0,0,0,2'd1, 2'd0,2'd0,0,0,1));
      tbl.push_back(mk(0,1,0,2'd0, 2'd2,2'd1,0,0,1));

      // table-driven opening sequence
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].f, tbl[i].l, tbl[i].p, tbl[i].d);
         chk($sformatf("v%0d_req", i), 32'(req), 32'(tbl[i].rq));
         chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tbl[i].sl));
         chk($sformatf("v%0d_pxl", i), 32'(pxl), 32'(tbl[i].px));
         chk($sformatf("v%0d_und", i), 32'(und), 32'(tbl[i].u));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e));
      end

      // underrun: done[1] withheld past line 4, then async reset mid-fill
      do_reset();
      cyc(1, 0, 0, 2'b00);
      cyc(0, 0, 0, 2'b01);
      for (int l = 0; l < 4; l++) cyc(0, 1, 0, 2'b00);
      chk("und_pre", 32'(und), 0);
      cyc(0, 1, 0, 2'b00);
      chk("und_set", 32'(und), 1);
      chk("und_sel", 32'(sel), 2);
      chk("und_req", 32'(req), 2);
      repeat (3) cyc(0, 0, 0, 2'b00);
      chk("und_req_hold", 32'(req), 2);
      cyc(0, 0, 0, 2'b10);
      chk("und_req_drop", 32'(req), 0);
      cyc(0, 0, 0, 2'b00);
      chk("und_next_req", 32'(req), 1);
      cyc(0, 0, 0, 2'b01);
      chk("und_next_done", 32'(req), 0);
      chk("und_sticky", 32'(und), 1);
      for (int l = 0; l < 4; l++) cyc(0, 1, 0, 2'b00);
      chk("und_l8_sel", 32'(sel), 1);
      chk("und_l8_req", 32'(req), 2);
      #2;
      rstn_i = 1'b0;
      #1;
      chk("async_rst_req", 32'(req), 0);
      chk("async_rst_sel", 32'(sel), 0);
      chk("async_rst_und", 32'(und), 0);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;

      // frame_start at line 200 with the row-50 fill pending
      do_reset();
      cyc(1, 0, 0, 2'b00);
      cyc(0, 0, 0, 2'b01);
      for (int l = 0; l < 200; l++) begin
         cyc(0, 1, 0, 2'b00);
         if (l == 196) begin
            chk("l196_sel", 32'(sel), 2);
            chk("l196_req", 32'(req), 1);
         end
         if (req != 2'b00 && l < 196) cyc(0, 0, 0, req);
      end
      chk("fe_pre_err", 32'(err), 0);
      chk("fe_pre_und", 32'(und), 0);
      cyc(1, 0, 0, 2'b00);
      chk("fe_sel", 32'(sel), 0);
      chk("fe_err", 32'(err), 1);
      chk("fe_req_pending", 32'(req), 1);
      cyc(0, 0, 0, 2'b00);
      chk("fe_req_hold", 32'(req), 1);
      cyc(0, 0, 0, 2'b01);
      chk("fe_req_gap", 32'(req), 0);
      cyc(0, 0, 0, 2'b00);
      chk("fe_req_row0", 32'(req), 1);
      cyc(0, 0, 0, 2'b01);
      chk("fe_primed", 32'(req), 0);
      cyc(0, 1, 0, 2'b00);
      chk("fe_l0_sel", 32'(sel), 1);
      chk("fe_l0_req", 32'(req), 2);

      // 640+ pixel strobes on one line
      do_reset();
      cyc(1, 0, 0, 2'b00);
      cyc(0, 0, 0, 2'b01);
      cyc(0, 1, 0, 2'b00);
      for (int n = 1; n <= 648; n++) begin
         cyc(0, 0, 1, 2'b00);
         chk($sformatf("pxl_n%0d", n), 32'(pxl), 32'((n / 4 > 159) ? 159 : n / 4));
      end

      // randomized full frame against the reference
      do_reset();
      line_idx = -1; px_cnt = 0; fills = 0; cd = 0;
      armed = 1'b0; prev_req = 2'b00;
      rcyc(1, 0);
      repeat (20) rcyc(0, 0);
      chk("rnd_primed", 32'(req), 0);
      for (int ln = 0; ln < 480; ln++) begin
         rcyc(0, 1);
         if (ln == 476) chk("rnd_no_req_476", 32'(req), 0);
         repeat (9 + $urandom_range(0, 3)) rcyc(0, 0);
      end
      chk("rnd_fill_count", 32'(fills), 120);
      repeat (5) rcyc(0, 0);
      chk("rnd_end_sel", 32'(sel), 2);
      chk("rnd_end_req", 32'(req), 0);
      chk("rnd_end_und", 32'(und), 0);
      chk("rnd_end_err", 32'(err), 0);
      rcyc(0, 1);
      chk("rnd_extra_line_err", 32'(err), 1);
      chk("rnd_extra_line_sel", 32'(sel), 2);
      rcyc(1, 0);
      chk("rnd_next_frame_sel", 32'(sel), 0);
      chk("rnd_next_frame_req", 32'(req), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
